// File: rtl/button_event_pkg.sv
// Shared types for the button event controller: event codes, per-button FSM states
// and the timestamp width.
package button_event_pkg;

  localparam int TIMESTAMP_WIDTH = 16;

  typedef enum logic [1:0] {
    EV_PRESS   = 2'd0,
    EV_RELEASE = 2'd1,
    EV_LONG    = 2'd2,
    EV_REPEAT  = 2'd3
  } event_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DOWN = 2'd1,
    ST_HELD = 2'd2
  } fsm_state_t;

endpackage

// File: rtl/button_event_fsm.sv
// Per-button press/long/repeat FSM. The event strobe is combinational from the
// current state and edge/tick inputs so it lands in the pending slot one cycle later.
module button_event_fsm
  import button_event_pkg::*;
#(
  parameter int HOLD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  tick,
  input  logic                  rise,
  input  logic                  fall,
  input  logic [HOLD_WIDTH-1:0] long_ticks,
  input  logic [HOLD_WIDTH-1:0] repeat_ticks,
  output logic                  ev_stb,
  output event_type_t           ev_type
);

  fsm_state_t            state, state_nxt;
  logic [HOLD_WIDTH-1:0] cnt, cnt_nxt, cnt_inc;

  function automatic logic [HOLD_WIDTH-1:0] sat_inc(input logic [HOLD_WIDTH-1:0] v);
    return (v == '1) ? v : v + HOLD_WIDTH'(1);
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    ev_stb    = 1'b0;
    ev_type   = EV_PRESS;
    cnt_inc   = sat_inc(cnt);
    case (state)
      ST_IDLE: begin
        if (rise) begin
          ev_stb    = 1'b1;
          ev_type   = EV_PRESS;
          state_nxt = ST_DOWN;
          cnt_nxt   = '0;
        end
      end
      // Release wins over a threshold crossing in the same cycle
      ST_DOWN: begin
        if (fall) begin
          ev_stb    = 1'b1;
          ev_type   = EV_RELEASE;
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if ((long_ticks != '0) && (cnt_inc >= long_ticks)) begin
            ev_stb    = 1'b1;
            ev_type   = EV_LONG;
            state_nxt = ST_HELD;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      ST_HELD: begin
        if (fall) begin
          ev_stb    = 1'b1;
          ev_type   = EV_RELEASE;
          state_nxt = ST_IDLE;
        end else if (tick) begin
          if ((repeat_ticks != '0) && (cnt_inc >= repeat_ticks)) begin
            ev_stb  = 1'b1;
            ev_type = EV_REPEAT;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Debounced buttons -> PRESS/RELEASE/LONG/REPEAT events on one valid/ready port,
// round-robin shared. Define BUTTON_EVENT_TIMESTAMP_EN to add o_event_timestamp.
module button_event_ctrl
  import button_event_pkg::*;
#(
  parameter int BUTTON_COUNT   = 5,
  parameter int PRESCALE_WIDTH = 24,
  parameter int HOLD_WIDTH     = 8
) (
  input  logic                            i_clock,
  input  logic                            i_reset,
  input  logic [PRESCALE_WIDTH-1:0]       i_tick_period,
  input  logic [HOLD_WIDTH-1:0]           i_long_press_ticks,
  input  logic [HOLD_WIDTH-1:0]           i_repeat_ticks,
  input  logic [BUTTON_COUNT-1:0]         i_buttons,
  output logic                            o_event_valid,
  input  logic                            i_event_ready,
  output logic [$clog2(BUTTON_COUNT)-1:0] o_event_button,
  output logic [1:0]                      o_event_type,
  output logic                            o_event_drop
`ifdef BUTTON_EVENT_TIMESTAMP_EN
  ,
  output logic [TIMESTAMP_WIDTH-1:0]      o_event_timestamp
`endif
);

  localparam int IDX_W = $clog2(BUTTON_COUNT);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BUTTON_COUNT - 1);

  logic [PRESCALE_WIDTH-1:0] presc_cnt;
  logic                      tick;
  logic [BUTTON_COUNT-1:0]   btn_p0, btn_p1, rise, fall, ev_stb, drop_now;
  event_type_t               ev_type [BUTTON_COUNT];
  logic [BUTTON_COUNT-1:0]   pend_vld_p1;
  event_type_t               pend_type_p1 [BUTTON_COUNT];
  logic [IDX_W-1:0]          rr_ptr, winner, out_button_p2;
  event_type_t               out_type_p2;
  logic                      vld_p2, drop_p2, any_pend, load, grant;
  int                        scan;

  // Shared time base: >= keeps the tick coming if the period is lowered mid-count
  assign tick = (presc_cnt >= i_tick_period);

  always_ff @(posedge i_clock) begin
    if (i_reset) presc_cnt <= '0;
    else         presc_cnt <= tick ? '0 : presc_cnt + PRESCALE_WIDTH'(1);
  end

  // Stage p0/p1: input sample and previous sample for edge detection
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      btn_p0 <= '0;
      btn_p1 <= '0;
    end else begin
      btn_p0 <= i_buttons;
      btn_p1 <= btn_p0;
    end
  end

  assign rise = btn_p0 & ~btn_p1;
  assign fall = ~btn_p0 & btn_p1;

  for (genvar g = 0; g < BUTTON_COUNT; g++) begin : g_fsm
    button_event_fsm #(.HOLD_WIDTH(HOLD_WIDTH)) u_fsm (
      .clk         (i_clock),
      .rst         (i_reset),
      .tick        (tick),
      .rise        (rise[g]),
      .fall        (fall[g]),
      .long_ticks  (i_long_press_ticks),
      .repeat_ticks(i_repeat_ticks),
      .ev_stb      (ev_stb[g]),
      .ev_type     (ev_type[g])
    );
  end

  // Round-robin search starting at rr_ptr, wrapping past the last button
  always_comb begin
    winner   = rr_ptr;
    any_pend = 1'b0;
    scan     = 0;
    for (int k = 0; k < BUTTON_COUNT; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= BUTTON_COUNT) scan = scan - BUTTON_COUNT;
      if (!any_pend && pend_vld_p1[scan]) begin
        any_pend = 1'b1;
        winner   = IDX_W'(scan);
      end
    end
  end

  assign load  = !vld_p2 || i_event_ready;
  assign grant = load && any_pend;

  always_comb begin
    drop_now = '0;
    for (int i = 0; i < BUTTON_COUNT; i++)
      drop_now[i] = ev_stb[i] && pend_vld_p1[i] && !(grant && (winner == IDX_W'(i)));
  end

  // Stage p1: one pending slot per button; a fresh event always overwrites
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      pend_vld_p1 <= '0;
      drop_p2     <= 1'b0;
    end else begin
      for (int i = 0; i < BUTTON_COUNT; i++) begin
        if (ev_stb[i])                                  pend_vld_p1[i] <= 1'b1;
        else if (grant && (winner == IDX_W'(i)))        pend_vld_p1[i] <= 1'b0;
      end
      drop_p2 <= |drop_now;
    end
  end

  always_ff @(posedge i_clock) begin
    for (int i = 0; i < BUTTON_COUNT; i++)
      if (ev_stb[i]) pend_type_p1[i] <= ev_type[i];
  end

  // Stage p2: output register, held while valid && !ready
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      vld_p2        <= 1'b0;
      out_button_p2 <= '0;
      out_type_p2   <= EV_PRESS;
      rr_ptr        <= '0;
    end else if (load) begin
      vld_p2 <= any_pend;
      if (any_pend) begin
        out_button_p2 <= winner;
        out_type_p2   <= pend_type_p1[winner];
        rr_ptr        <= (winner == LAST_IDX) ? '0 : winner + IDX_W'(1);
      end
    end
  end

  assign o_event_valid  = vld_p2;
  assign o_event_button = out_button_p2;
  assign o_event_type   = out_type_p2;
  assign o_event_drop   = drop_p2;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
  logic [TIMESTAMP_WIDTH-1:0] ts_cnt, out_ts_p2;
  logic [TIMESTAMP_WIDTH-1:0] pend_ts_p1 [BUTTON_COUNT];

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      ts_cnt    <= '0;
      out_ts_p2 <= '0;
    end else begin
      if (tick)  ts_cnt    <= ts_cnt + TIMESTAMP_WIDTH'(1);
      if (grant) out_ts_p2 <= pend_ts_p1[winner];
    end
  end

  always_ff @(posedge i_clock) begin
    for (int i = 0; i < BUTTON_COUNT; i++)
      if (ev_stb[i]) pend_ts_p1[i] <= ts_cnt;
  end

  assign o_event_timestamp = out_ts_p2;
`endif

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl: cycle-exact vector table plus
// multi-cycle sequences for long/repeat, round-robin, stall/drop and reset.
module tb_button_event_ctrl;
  import button_event_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] tick_period;
  logic [7:0]  long_ticks, repeat_ticks;
  logic [4:0]  buttons;
  logic        ready;
  logic        ev_valid, ev_drop;
  logic [2:0]  ev_button;
  logic [1:0]  ev_type;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
  logic [15:0] ev_ts;
  logic [15:0] dts;
`endif

  always #5 clk = ~clk;

  button_event_ctrl #(.BUTTON_COUNT(5), .PRESCALE_WIDTH(24), .HOLD_WIDTH(8)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_tick_period     (tick_period),
    .i_long_press_ticks(long_ticks),
    .i_repeat_ticks    (repeat_ticks),
    .i_buttons         (buttons),
    .o_event_valid     (ev_valid),
    .i_event_ready     (ready),
    .o_event_button    (ev_button),
    .o_event_type      (ev_type),
    .o_event_drop      (ev_drop)
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    ,
    .o_event_timestamp (ev_ts)
`endif
  );

  typedef struct {
    logic [4:0] buttons;
    logic       ready;
    logic       vld;
    logic [2:0] btn;
    logic [1:0] typ;
    logic       drop;
  } vec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  btn;
    logic [1:0]  typ;
    logic [15:0] ts;
  } ev_t;

  vec_t vec [23];
  ev_t  ev_q [$];
  ev_t  mon_e;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   bad, drops, dt;

  // Accepted-event monitor
  always @(posedge clk) begin
    cyc++;
    if (ev_valid === 1'b1 && ready === 1'b1) begin
      mon_e.cyc = cyc;
      mon_e.btn = ev_button;
      mon_e.typ = ev_type;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
      mon_e.ts  = ev_ts;
`else
      mon_e.ts  = 16'd0;
`endif
      ev_q.push_back(mon_e);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vec[0]  = '{5'b00101, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[1]  = '{5'b00101, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[2]  = '{5'b00101, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0};
    vec[3]  = '{5'b00101, 1'b0, 1'b1, 3'd0, 2'd0, 1'b0};
    vec[4]  = '{5'b00101, 1'b1, 1'b1, 3'd2, 2'd0, 1'b0};
    vec[5]  = '{5'b00100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[6]  = '{5'b00100, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[7]  = '{5'b00100, 1'b1, 1'b1, 3'd0, 2'd1, 1'b0};
    vec[8]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[9]  = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[10] = '{5'b00000, 1'b0, 1'b1, 3'd2, 2'd1, 1'b0};
    vec[11] = '{5'b10000, 1'b0, 1'b1, 3'd2, 2'd1, 1'b0};
    vec[12] = '{5'b10000, 1'b0, 1'b1, 3'd2, 2'd1, 1'b0};
    vec[13] = '{5'b10000, 1'b1, 1'b1, 3'd4, 2'd0, 1'b0};
    vec[14] = '{5'b10000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[15] = '{5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[16] = '{5'b00000, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0};
    vec[17] = '{5'b00000, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vec[18] = '{5'b10000, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vec[19] = '{5'b00000, 1'b0, 1'b1, 3'd4, 2'd1, 1'b0};
    vec[20] = '{5'b00000, 1'b0, 1'b1, 3'd4, 2'd1, 1'b1};
    vec[21] = '{5'b00000, 1'b1, 1'b1, 3'd4, 2'd1, 1'b0};
    vec[22] = '{5'b00000, 1'b1, 1'b0, 3'd0, 2'd0, 1'b0};

    rst = 1'b1; buttons = '0; ready = 1'b0;
    tick_period = 24'd1000; long_ticks = 8'd0; repeat_ticks = 8'd0;
    tick_n(3);
    check("reset_valid",  ev_valid,  0);
    check("reset_button", ev_button, 0);
    check("reset_type",   ev_type,   0);
    check("reset_drop",   ev_drop,   0);
    rst = 1'b0;

    // Cycle-exact table: PRESS/RELEASE latency, stall, round-robin, overwrite drop
    for (int i = 0; i < 23; i++) begin
      buttons = vec[i].buttons;
      ready   = vec[i].ready;
      tick_n(1);
      check($sformatf("vec%0d_valid", i), ev_valid, vec[i].vld);
      check($sformatf("vec%0d_drop", i),  ev_drop,  vec[i].drop);
      if (vec[i].vld) begin
        check($sformatf("vec%0d_button", i), ev_button, vec[i].btn);
        check($sformatf("vec%0d_type", i),   ev_type,   vec[i].typ);
      end
    end
    tick_n(5);

    // A: long press with repeats on button 1
    tick_period = 24'd9; long_ticks = 8'd5; repeat_ticks = 8'd2; ready = 1'b1;
    ev_q.delete();
    buttons = 5'b00010;
    tick_n(200);
    buttons = 5'b00000;
    tick_n(30);
    check("A_count", ev_q.size(), 10);
    if (ev_q.size() == 10) begin
      bad = 0;
      foreach (ev_q[i]) if (ev_q[i].btn != 3'd1) bad++;
      check("A_button", bad, 0);
      check("A_press", ev_q[0].typ, EV_PRESS);
      check("A_long", ev_q[1].typ, EV_LONG);
      dt = ev_q[1].cyc - ev_q[0].cyc;
      check("A_long_delay_41_to_50", (dt >= 41 && dt <= 50), 1);
      for (int m = 2; m < 9; m++) begin
        check($sformatf("A_repeat%0d_type", m), ev_q[m].typ, EV_REPEAT);
        check($sformatf("A_repeat%0d_gap", m), ev_q[m].cyc - ev_q[m-1].cyc, 20);
      end
      check("A_release", ev_q[9].typ, EV_RELEASE);
      check("A_hold_cycles", ev_q[9].cyc - ev_q[0].cyc, 200);
    end

    // B: short press on button 3
    ev_q.delete();
    buttons = 5'b01000;
    tick_n(30);
    buttons = 5'b00000;
    tick_n(20);
    check("B_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("B_press", ev_q[0].typ, EV_PRESS);
      check("B_release", ev_q[1].typ, EV_RELEASE);
      check("B_button", {ev_q[0].btn, ev_q[1].btn}, {3'd3, 3'd3});
    end

    // C: rr pointer moved to 3, then simultaneous presses on 0,2,4
    long_ticks = 8'd0;
    buttons = 5'b00100;
    tick_n(5);
    buttons = 5'b00000;
    tick_n(10);
    ev_q.delete();
    buttons = 5'b10101;
    tick_n(10);
    check("C_count", ev_q.size(), 3);
    if (ev_q.size() == 3) begin
      check("C_order0", ev_q[0].btn, 4);
      check("C_order1", ev_q[1].btn, 0);
      check("C_order2", ev_q[2].btn, 2);
      check("C_types", {ev_q[0].typ, ev_q[1].typ, ev_q[2].typ}, 0);
      check("C_gap1", ev_q[1].cyc - ev_q[0].cyc, 1);
      check("C_gap2", ev_q[2].cyc - ev_q[1].cyc, 1);
    end
    buttons = 5'b00000;
    tick_n(10);

    // D: stalled output while button 2 repeats into its pending slot
    tick_period = 24'd0; long_ticks = 8'd5; repeat_ticks = 8'd3; ready = 1'b0;
    buttons = 5'b00100;
    drops = 0; bad = 0;
    for (int i = 0; i < 50; i++) begin
      tick_n(1);
      if (ev_drop === 1'b1) drops++;
      if (i < 2) begin
        if (ev_valid !== 1'b0) bad++;
      end else if (ev_valid !== 1'b1 || ev_button !== 3'd2 || ev_type !== 2'd0) begin
        bad++;
      end
    end
    check("D_frozen_output", bad, 0);
    check("D_drop_pulses", drops, 14);
    ready = 1'b1;
    tick_n(1);
    check("D_latest_valid", ev_valid, 1);
    check("D_latest_button", ev_button, 2);
    check("D_latest_type", ev_type, EV_REPEAT);
    buttons = 5'b00000;
    tick_n(20);

    // E: reset while HELD with a stalled output and an occupied slot
    long_ticks = 8'd2; repeat_ticks = 8'd4; ready = 1'b0;
    buttons = 5'b00010;
    tick_n(6);
    check("E_stalled_before_reset", ev_valid, 1);
    rst = 1'b1;
    tick_n(1);
    check("E_rst_valid", ev_valid, 0);
    check("E_rst_button", ev_button, 0);
    check("E_rst_type", ev_type, 0);
    check("E_rst_drop", ev_drop, 0);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    check("E_rst_ts", ev_ts, 0);
`endif
    rst = 1'b0; ready = 1'b1;
    tick_n(1);
    check("E_k0_valid", ev_valid, 0);
    tick_n(1);
    check("E_k1_valid", ev_valid, 0);
    tick_n(1);
    check("E_k2_valid", ev_valid, 1);
    check("E_k2_button", ev_button, 1);
    check("E_k2_type", ev_type, EV_PRESS);
    tick_n(1);
    check("E_k3_valid", ev_valid, 0);
    tick_n(1);
    check("E_long_after_reset", ev_type, EV_LONG);
    buttons = 5'b00000;
    tick_n(20);

    // F: LONG disabled, long hold on button 0
    long_ticks = 8'd0;
    ev_q.delete();
    buttons = 5'b00001;
    tick_n(1000);
    buttons = 5'b00000;
    tick_n(20);
    check("F_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("F_press", ev_q[0].typ, EV_PRESS);
      check("F_release", ev_q[1].typ, EV_RELEASE);
      check("F_button", {ev_q[0].btn, ev_q[1].btn}, 0);
`ifdef BUTTON_EVENT_TIMESTAMP_EN
      dts = ev_q[1].ts - ev_q[0].ts;
      check("F_ts_delta", dts, 1000);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
